// File: rtl/bf_perceptron_trainer_if.sv
// rtl/bf_perceptron_trainer_if.sv - read/predict/resolve/update signal bundle for bf_perceptron_trainer
interface bf_perceptron_trainer_if;
    logic         rd_valid;
    logic         rd_ready;
    logic [143:0] weights_rd;
    logic [47:0]  hist;
    logic [767:0] index_rd;
    logic         pred_valid;
    logic         pred_taken;
    logic [8:0]   pred_sum;
    logic         res_valid;
    logic         res_taken;
    logic         upd_en;
    logic [143:0] upd_weights;
    logic [767:0] upd_index;
    logic         err_underflow;

    modport master (
        output rd_valid, weights_rd, hist, index_rd, res_valid, res_taken,
        input  rd_ready, pred_valid, pred_taken, pred_sum,
               upd_en, upd_weights, upd_index, err_underflow
    );

    modport slave (
        input  rd_valid, weights_rd, hist, index_rd, res_valid, res_taken,
        output rd_ready, pred_valid, pred_taken, pred_sum,
               upd_en, upd_weights, upd_index, err_underflow
    );
endinterface

// File: rtl/bf_perceptron_trainer.sv
// rtl/bf_perceptron_trainer.sv - perceptron sum/predict pipeline with in-flight FIFO and saturating trainer
module bf_perceptron_trainer #(
    parameter int DEPTH = 4,
    parameter int THETA = 106
) (
    input  logic                   clk,
    input  logic                   rst,
    bf_perceptron_trainer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [8:0] THETA_U = 9'(THETA);

    // All sums are carried as two's-complement bit patterns in unsigned vectors.
    function automatic logic [6:0] contrib(input logic [2:0] w, input logic h);
        logic [3:0] w4;
        logic [3:0] c;
        w4 = {w[2], w};
        c  = h ? w4 : 4'd0 - w4;
        return {{3{c[3]}}, c};
    endfunction

    logic         s1_valid, s2_valid;
    logic [143:0] s1_w, s2_w;
    logic [47:0]  s1_h, s2_h;
    logic [767:0] s1_idx, s2_idx;
    logic [6:0]   s1_part [6];
    logic [6:0]   part_c  [6];
    logic [8:0]   sum_c, s2_sum;
    logic         s2_taken;

    logic [143:0] f_w   [DEPTH];
    logic [47:0]  f_h   [DEPTH];
    logic [767:0] f_idx [DEPTH];
    logic [8:0]   f_sum [DEPTH];
    logic         f_tkn [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] occ;

    logic         rd_ready, accept, push, pop, train;
    logic [8:0]   mag;
    logic [143:0] new_w;
    logic         upd_en_q, err_q;
    logic [143:0] upd_w_q;
    logic [767:0] upd_idx_q;

    // Reads still in S1/S2 count against capacity so every push is guaranteed a slot.
    assign occ      = {1'b0, count} + {{(AW+1){1'b0}}, s1_valid} + {{(AW+1){1'b0}}, s2_valid};
    assign rd_ready = occ < (AW+2)'(DEPTH);
    assign accept   = bus.rd_valid & rd_ready;
    assign push     = s2_valid;
    assign pop      = bus.res_valid & (count != '0);

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 6; k++) begin
            part_c[k] = '0;
            for (int j = 0; j < 8; j++)
                part_c[k] = part_c[k] + contrib(bus.weights_rd[3*(8*k+j) +: 3], bus.hist[8*k+j]);
            sum_c = sum_c + {{2{s1_part[k][6]}}, s1_part[k]};
        end
    end

    assign mag   = f_sum[rd_ptr][8] ? 9'd0 - f_sum[rd_ptr] : f_sum[rd_ptr];
    assign train = (f_tkn[rd_ptr] != bus.res_taken) | (mag <= THETA_U);

    always_comb begin
        new_w = f_w[rd_ptr];
        for (int i = 0; i < 48; i++) begin
            if (f_h[rd_ptr][i] == bus.res_taken) begin
                if (f_w[rd_ptr][3*i +: 3] != 3'b011)
                    new_w[3*i +: 3] = f_w[rd_ptr][3*i +: 3] + 3'd1;
            end else if (f_w[rd_ptr][3*i +: 3] != 3'b100) begin
                new_w[3*i +: 3] = f_w[rd_ptr][3*i +: 3] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_w   <= bus.weights_rd;
            s1_h   <= bus.hist;
            s1_idx <= bus.index_rd;
            s1_part <= part_c;
        end
        if (s1_valid) begin
            s2_w   <= s1_w;
            s2_h   <= s1_h;
            s2_idx <= s1_idx;
        end
        if (push) begin
            f_w[wr_ptr]   <= s2_w;
            f_h[wr_ptr]   <= s2_h;
            f_idx[wr_ptr] <= s2_idx;
            f_sum[wr_ptr] <= s2_sum;
            f_tkn[wr_ptr] <= s2_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_taken  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            upd_en_q  <= 1'b0;
            err_q     <= 1'b0;
            upd_w_q   <= '0;
            upd_idx_q <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= sum_c;
                s2_taken <= ~sum_c[8];
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            err_q    <= bus.res_valid & (count == '0);
            upd_en_q <= pop & train;
            if (pop) begin
                upd_w_q   <= train ? new_w : f_w[rd_ptr];
                upd_idx_q <= f_idx[rd_ptr];
            end
        end
    end

    assign bus.rd_ready      = rd_ready;
    assign bus.pred_valid    = s2_valid;
    assign bus.pred_sum      = s2_sum;
    assign bus.pred_taken    = s2_taken;
    assign bus.upd_en        = upd_en_q;
    assign bus.upd_weights   = upd_w_q;
    assign bus.upd_index     = upd_idx_q;
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_bf_perceptron_trainer.sv
// tb/tb_bf_perceptron_trainer.sv - scoreboard bench for bf_perceptron_trainer
module tb_bf_perceptron_trainer;
    localparam int DEPTH = 4;
    localparam int THETA = 106;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bf_perceptron_trainer_if bus();
    bf_perceptron_trainer #(.DEPTH(DEPTH), .THETA(THETA)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int           cyc;
        logic [143:0] w;
        logic [47:0]  h;
        logic [767:0] idx;
        int           sum;
        logic         taken;
    } ent_t;
    typedef struct {
        logic         en;
        logic         err;
        logic [143:0] w;
        logic [767:0] idx;
    } upd_t;
    typedef struct {
        int   sum;
        logic taken;
    } pred_t;

    ent_t  pend[$];
    pred_t pred_q[$];
    upd_t  upd_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    logic  res_d1 = 1'b0;
    logic  mon_en = 1'b0;

    function automatic logic [143:0] fill_w(input int v);
        logic [143:0] r;
        for (int i = 0; i < 48; i++) r[3*i +: 3] = 3'(v);
        return r;
    endfunction

    function automatic logic [767:0] mk_idx(input int base);
        logic [767:0] r;
        for (int i = 0; i < 48; i++) r[16*i +: 16] = 16'(base + 7*i);
        return r;
    endfunction

    function automatic int wt(input logic [143:0] w, input int i);
        logic [2:0] b;
        b = w[3*i +: 3];
        return b[2] ? int'(b) - 8 : int'(b);
    endfunction

    function automatic int calc_sum(input logic [143:0] w, input logic [47:0] h);
        int s = 0;
        for (int i = 0; i < 48; i++) s += h[i] ? wt(w, i) : -wt(w, i);
        return s;
    endfunction

    function automatic upd_t calc_upd(input ent_t e, input logic rt);
        upd_t u;
        int   m;
        int   nv;
        m     = (e.sum < 0) ? -e.sum : e.sum;
        u.en  = (e.taken != rt) || (m <= THETA);
        u.err = 1'b0;
        u.idx = e.idx;
        u.w   = e.w;
        if (u.en) begin
            for (int i = 0; i < 48; i++) begin
                nv = wt(e.w, i) + ((e.h[i] == rt) ? 1 : -1);
                if (nv > 3)  nv = 3;
                if (nv < -4) nv = -4;
                u.w[3*i +: 3] = 3'(nv);
            end
        end
        return u;
    endfunction

    task automatic check(input string name, input logic [767:0] got, input logic [767:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Entries become resolvable three cycles after their read was issued.
    task automatic drive(input logic rv, input logic [143:0] w, input logic [47:0] h,
                         input logic [767:0] idx, input logic resv, input logic rt);
        ent_t e;
        upd_t u;
        if (rv) begin
            check("rd_ready_at_issue", 768'(bus.rd_ready), 768'(1));
            e.cyc = cyc; e.w = w; e.h = h; e.idx = idx;
            e.sum = calc_sum(w, h);
            e.taken = (e.sum >= 0);
            pend.push_back(e);
            pred_q.push_back('{sum: e.sum, taken: e.taken});
        end
        if (resv) begin
            if (pend.size() > 0 && pend[0].cyc + 3 <= cyc) begin
                e = pend.pop_front();
                upd_q.push_back(calc_upd(e, rt));
            end else begin
                u.en = 1'b0; u.err = 1'b1; u.w = '0; u.idx = '0;
                upd_q.push_back(u);
            end
        end
        bus.rd_valid   = rv;
        bus.weights_rd = w;
        bus.hist       = h;
        bus.index_rd   = idx;
        bus.res_valid  = resv;
        bus.res_taken  = rt;
        tick();
        bus.rd_valid  = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    task automatic rd(input logic [143:0] w, input logic [47:0] h, input logic [767:0] idx);
        drive(1'b1, w, h, idx, 1'b0, 1'b0);
    endtask

    task automatic rs(input logic rt);
        drive(1'b0, '0, '0, '0, 1'b1, rt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) res_d1 <= bus.res_valid & ~rst;

    always @(negedge clk) begin : monitor
        pred_t p;
        upd_t  u;
        if (mon_en) begin
            if (bus.pred_valid === 1'b1) begin
                if (pred_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_pred_valid got 1 want 0 at cycle %0d", cyc);
                end else begin
                    p = pred_q.pop_front();
                    check("pred_sum", 768'(bus.pred_sum), 768'(9'(p.sum)));
                    check("pred_taken", 768'(bus.pred_taken), 768'(p.taken));
                end
            end
            if (res_d1) begin
                if (upd_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL upd_unexpected got resolve want none at cycle %0d", cyc);
                end else begin
                    u = upd_q.pop_front();
                    check("upd_en", 768'(bus.upd_en), 768'(u.en));
                    check("err_underflow", 768'(bus.err_underflow), 768'(u.err));
                    if (!u.err) begin
                        check("upd_weights", 768'(bus.upd_weights), 768'(u.w));
                        check("upd_index", bus.upd_index, u.idx);
                    end
                end
            end else if (bus.upd_en !== 1'b0 || bus.err_underflow !== 1'b0) begin
                tests++; fails++;
                $display("FAIL spurious_update got en=%b err=%b want 0 0 at cycle %0d",
                         bus.upd_en, bus.err_underflow, cyc);
            end
        end
    end

    initial begin
        int acc;
        bus.rd_valid = 1'b0; bus.weights_rd = '0; bus.hist = '0; bus.index_rd = '0;
        bus.res_valid = 1'b0; bus.res_taken = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_rd_ready", 768'(bus.rd_ready), 768'(1));
        check("rst_pred_valid", 768'(bus.pred_valid), 768'(0));
        check("rst_pred_taken", 768'(bus.pred_taken), 768'(0));
        check("rst_pred_sum", 768'(bus.pred_sum), 768'(0));
        check("rst_upd_en", 768'(bus.upd_en), 768'(0));
        check("rst_err", 768'(bus.err_underflow), 768'(0));
        check("rst_upd_weights", 768'(bus.upd_weights), 768'(0));
        check("rst_upd_index", bus.upd_index, '0);
        rst = 1'b0;
        mon_en = 1'b1;

        // +3 everywhere, hist all 1: sum 144, correct -> no training
        rd(fill_w(3), {48{1'b1}}, mk_idx(100));
        idle(2);
        rs(1'b1);
        idle(1);

        // back-to-back: -4/hist 0, zero/alternating, +3/mixed hist (saturation)
        rd(fill_w(-4), '0, mk_idx(200));
        rd(fill_w(0), 48'h5555_5555_5555, mk_idx(300));
        rd(fill_w(3), 48'h0000_FFFF_FFFF, mk_idx(400));
        idle(2);
        rs(1'b0);
        rs(1'b1);
        rs(1'b1);
        idle(2);

        // fill to capacity without resolving
        acc = 0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            check("rd_ready_fill", 768'(bus.rd_ready), 768'(acc < DEPTH));
            if (bus.rd_ready === 1'b1) begin
                rd(fill_w((k % 8) - 4), 48'h0F0F_0F0F_0F0F ^ {48{k[0]}}, mk_idx(1000 + 50*k));
                acc++;
            end else begin
                idle(1);
            end
        end
        idle(2);
        for (int k = 0; k < DEPTH; k++) rs(k[0]);
        check("rd_ready_drained", 768'(bus.rd_ready), 768'(1));
        idle(2);

        // underflow on empty FIFO
        rs(1'b1);
        idle(2);

        // push and pop in the same cycle at count 2
        rd(fill_w(1), 48'hFFFF_0000_FFFF, mk_idx(2000));
        rd(fill_w(-2), 48'h00FF_00FF_00FF, mk_idx(3000));
        idle(2);
        rd(fill_w(2), 48'hAAAA_AAAA_AAAA, mk_idx(4000));
        idle(1);
        rs(1'b1);
        rs(1'b0);
        rs(1'b1);
        idle(2);

        // reset with three predictions in flight
        rd(fill_w(3), {48{1'b1}}, mk_idx(5000));
        rd(fill_w(-1), 48'h1234_5678_9ABC, mk_idx(6000));
        rd(fill_w(2), '0, mk_idx(7000));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pend.delete();
        pred_q.delete();
        upd_q.delete();
        for (int k = 0; k < 4; k++) begin
            check("post_rst_pred_valid", 768'(bus.pred_valid), 768'(0));
            check("post_rst_upd_en", 768'(bus.upd_en), 768'(0));
            idle(1);
        end
        rs(1'b1);
        idle(2);

        for (int k = 0; k < 50 && (pred_q.size() != 0 || upd_q.size() != 0); k++) idle(1);
        if (pred_q.size() != 0 || upd_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain got %0d/%0d pending want 0/0", pred_q.size(), upd_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
